wm_refill_fifo: RTL and testbench
=================================

# wm_refill_fifo

Parametrised synchronous FIFO with an integrated watermark-driven refill engine. An internal producer FSM writes generated data words into the FIFO until occupancy reaches a high watermark. It then stops until occupancy drains to a low watermark, which gives hysteresis refill behaviour. The block sits between a local data source and a downstream consumer that pops words with `rd_en`. Watermarks are runtime inputs, and the block can be disabled at runtime.

## Interface
- `DATA_WIDTH`, 8: word width; the generator wraps modulo 2^DATA_WIDTH.
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥ 2.
- `SEED`, 0: first generated data value after reset.
- `CW` (localparam) = $clog2(DEPTH)+1: count width.

- `clk`  in  1  sole clock; everything updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `refill_en`  in  1  enables the refill FSM.
- `hi_wm`  in  CW  occupancy at which refilling stops.
- `lo_wm`  in  CW  occupancy at or below which refilling resumes.
- `rd_en`  in  1  consumer pop request.
- `wr_en`  out  1  internal write strobe, exported for observation.
- `wr_data`  out  DATA_WIDTH  value being written this cycle.
- `data_out`  out  DATA_WIDTH  registered read data.
- `full`  out  1  `fifo_words == DEPTH`.
- `empty`  out  1  `fifo_words == 0`.
- `fifo_words`  out  CW  current occupancy, registered.
- `refilling`  out  1  FSM is in state FILL.
- `clr_err`  in  1  clears the sticky error flags.
- `underflow`  out  1  sticky error flag.
- `starved`  out  1  sticky error flag.

## Operation
- **Reset values:** state IDLE; pointers, `fifo_words` and `data_out` are 0; `empty` = 1; `full` = 0; generator = SEED; error flags = 0.
- **Effective watermarks:**
  - hi_eff = min(`hi_wm`, DEPTH).
  - lo_eff = min(`lo_wm`, hi_eff−1); lo_eff is 0 when hi_eff = 0.
  - Both are sampled live every cycle.
- **Write strobe:** `wr_en` = (state == FILL) && !`full` && hi_eff != 0, combinational from registered state.
- **Generator:** `wr_data` = generator value; it increments by 1 on every accepted write and wraps modulo 2^DATA_WIDTH.
- **Read:** `rd_en` && !`empty` pops `mem[rd_ptr]` into `data_out`. `rd_en` while empty is ignored and `data_out` holds its value.
- **Occupancy:** count_next = `fifo_words` + write − read; pointers wrap modulo DEPTH.
- **FSM states:**
  - IDLE → FILL when `refill_en` = 1.
  - FILL → HOLD when count_next ≥ hi_eff.
  - HOLD → FILL when count_next ≤ lo_eff.
  - FILL or HOLD → IDLE when `refill_en` = 0; this takes priority over all other transitions.
- **Simultaneous read and write:** both happen; occupancy is unchanged.
- **Full:** no write is possible because `wr_en` is masked.

## Timing
- Read latency is 1 cycle: `data_out` is valid the cycle after `rd_en` is sampled with the FIFO non-empty.
- A write lands on the edge where `wr_en` = 1. It is visible in `fifo_words` and readable from the next cycle.
- The FSM transitions on the same edge as the count update. The refill stop therefore lands exactly at hi_eff, and `wr_en` asserts in the first cycle in which `fifo_words` ≤ lo_eff.
- `refill_en` deassertion drops `wr_en` the cycle after it is sampled low.
- Reset asserted mid-operation restores all reset values on the next edge and discards FIFO contents.

## Configuration
- Macro: `WM_FIFO_ERR_EN`.
- **Defined:**
  - `underflow` sets on `rd_en` && `empty`.
  - `starved` sets when `empty` && state == FILL && `rd_en`.
  - Both flags are sticky and clear on reset or on `clr_err` (clear has priority over set).
- **Undefined:** `underflow` and `starved` are tied to 0, `clr_err` is ignored, and no flag logic is synthesised.

## Test plan
Configuration for all scenarios: DEPTH=8, DATA_WIDTH=8, SEED=0, `hi_wm`=6, `lo_wm`=2.
1. **Fill to high watermark.** Reset, then `refill_en`=1, `rd_en`=0 → `wr_en` high for 6 cycles with `wr_data` 0..5. `fifo_words` settles at 6, state HOLD, `wr_en`=0 thereafter.
2. **Drain to low watermark.** From scenario 1, `rd_en`=1 for 4 cycles → `fifo_words` 5,4,3,2 and `data_out` 0,1,2,3. `wr_en`=1 in the cycle `fifo_words` = 2.
3. **Simultaneous read and write.** Keep `rd_en`=1 → `fifo_words` holds at 2, `data_out` continues 4,5,…, and writes carry 6,7,….
4. **Watermark clamp.** `hi_wm`=10, `rd_en`=0 → fills to 8, `full`=1, `wr_en`=0, state HOLD.
5. **Read on empty.** `refill_en`=0 and drain until `empty`, then one more `rd_en` → `fifo_words` stays 0 and `data_out` holds. With `WM_FIFO_ERR_EN`, `underflow`=1 until `clr_err`.
6. **Reset mid-refill.** `rst_n`=0 for one cycle during FILL → `fifo_words`=0, `empty`=1, state IDLE, and the next write carries `wr_data`=0.

Source files
------------

// File: rtl/wm_refill_fifo_if.sv
// Consumer-side bus of the watermark refill FIFO: pop request, read data and occupancy status.
interface wm_refill_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
    logic [CW-1:0]         fifo_words;

    modport master (output rd_en, input data_out, empty, full, fifo_words);
    modport slave  (input rd_en, output data_out, empty, full, fifo_words);
endinterface

// File: rtl/wm_refill_fifo.sv
// Synchronous FIFO with a hysteresis refill engine that fills to hi_wm and resumes at lo_wm.
// Optional sticky underflow/starved flags are built when WM_FIFO_ERR_EN is defined.
module wm_refill_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int SEED       = 0,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  refill_en,
    input  logic [CW-1:0]         hi_wm,
    input  logic [CW-1:0]         lo_wm,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  refilling,
    input  logic                  clr_err,
    output logic                  underflow,
    output logic                  starved,
    wm_refill_fifo_if.slave       bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    function automatic logic [CW-1:0] f_min(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t                r_state;
    logic                  r_refilling;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_words;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] r_gen;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [CW-1:0] w_hi_eff;
    logic [CW-1:0] w_lo_eff;
    logic          w_empty;
    logic          w_full;
    logic          w_wr;
    logic          w_rd;
    logic [CW-1:0] w_count_next;

    assign w_hi_eff     = f_min(hi_wm, CW'(DEPTH));
    // Low mark kept strictly below the high mark so the hysteresis band never collapses.
    assign w_lo_eff     = (w_hi_eff == '0) ? '0 : f_min(lo_wm, w_hi_eff - CW'(1));
    assign w_empty      = (r_words == '0);
    assign w_full       = (r_words == CW'(DEPTH));
    assign w_wr         = (r_state == FILL) && !w_full && (w_hi_eff != '0);
    assign w_rd         = bus.rd_en && !w_empty;
    assign w_count_next = r_words + CW'(w_wr) - CW'(w_rd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_refilling <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (refill_en) begin
                        r_state     <= FILL;
                        r_refilling <= 1'b1;
                    end
                end
                FILL: begin
                    if (!refill_en) begin
                        r_state     <= IDLE;
                        r_refilling <= 1'b0;
                    end else if (w_count_next >= w_hi_eff) begin
                        r_state     <= HOLD;
                        r_refilling <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!refill_en) begin
                        r_state     <= IDLE;
                        r_refilling <= 1'b0;
                    end else if (w_count_next <= w_lo_eff) begin
                        r_state     <= FILL;
                        r_refilling <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_refilling <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_words    <= '0;
            r_data_out <= '0;
            r_gen      <= DATA_WIDTH'(SEED);
        end else begin
            r_words <= w_count_next;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_gen    <= r_gen + DATA_WIDTH'(1);
            end
            if (w_rd) begin
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    // Storage is not reset; pointer reset alone discards the contents.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_gen;
        end
    end

    assign wr_en          = w_wr;
    assign wr_data        = r_gen;
    assign refilling      = r_refilling;
    assign bus.data_out   = r_data_out;
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.fifo_words = r_words;

`ifdef WM_FIFO_ERR_EN
    logic r_underflow;
    logic r_starved;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_err) begin
            r_underflow <= 1'b0;
            r_starved   <= 1'b0;
        end else begin
            if (bus.rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (bus.rd_en && w_empty && (r_state == FILL)) begin
                r_starved <= 1'b1;
            end
        end
    end

    assign underflow = r_underflow;
    assign starved   = r_starved;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_err;
    assign underflow    = 1'b0;
    assign starved      = 1'b0;
`endif

endmodule

// File: tb/tb_wm_refill_fifo.sv
// Directed scenario bench for wm_refill_fifo (DEPTH=8, DATA_WIDTH=8, SEED=0, hi_wm=6, lo_wm=2).
module tb_wm_refill_fifo;
    localparam int DW = 8;
    localparam int DP = 8;
    localparam int CW = $clog2(DP) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          refill_en;
    logic [CW-1:0] hi_wm;
    logic [CW-1:0] lo_wm;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          refilling;
    logic          clr_err;
    logic          underflow;
    logic          starved;

    int pass_cnt  = 0;
    int total_cnt = 0;

    wm_refill_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    wm_refill_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .SEED(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .refill_en (refill_en),
        .hi_wm     (hi_wm),
        .lo_wm     (lo_wm),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .refilling (refilling),
        .clr_err   (clr_err),
        .underflow (underflow),
        .starved   (starved),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        refill_en = 1'b0;
        hi_wm     = CW'(6);
        lo_wm     = CW'(2);
        clr_err   = 1'b0;
        bus.rd_en = 1'b0;
        step();
        step();
        total_cnt++; if (bus.fifo_words !== 4'd0) $display("FAIL reset_words got %0d want 0", bus.fifo_words); else pass_cnt++;
        total_cnt++; if (bus.empty !== 1'b1) $display("FAIL reset_empty got %b want 1", bus.empty); else pass_cnt++;
        total_cnt++; if (bus.full !== 1'b0) $display("FAIL reset_full got %b want 0", bus.full); else pass_cnt++;
        total_cnt++; if (bus.data_out !== 8'd0) $display("FAIL reset_data_out got %0d want 0", bus.data_out); else pass_cnt++;
        total_cnt++; if (refilling !== 1'b0 || wr_en !== 1'b0) $display("FAIL reset_idle got refilling=%b wr_en=%b want 0 0", refilling, wr_en); else pass_cnt++;
        total_cnt++; if (wr_data !== 8'd0) $display("FAIL reset_wr_data got %0d want 0", wr_data); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        refill_en = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            total_cnt++;
            if (wr_en !== 1'b1 || wr_data !== DW'(i) || bus.fifo_words !== CW'(i))
                $display("FAIL fill_%0d got wr_en=%b wr_data=%0d words=%0d want 1 %0d %0d", i, wr_en, wr_data, bus.fifo_words, i, i);
            else pass_cnt++;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (bus.fifo_words !== 4'd6 || wr_en !== 1'b0 || refilling !== 1'b0)
                $display("FAIL fill_hold_%0d got words=%0d wr_en=%b refilling=%b want 6 0 0", i, bus.fifo_words, wr_en, refilling);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_drain();
        bus.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++;
            if (bus.fifo_words !== CW'(5 - i) || bus.data_out !== DW'(i) || wr_en !== (i == 3))
                $display("FAIL drain_%0d got words=%0d data_out=%0d wr_en=%b want %0d %0d %b", i, bus.fifo_words, bus.data_out, wr_en, 5 - i, i, (i == 3));
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (wr_en !== 1'b1 || wr_data !== DW'(6 + i))
                $display("FAIL b2b_wr_%0d got wr_en=%b wr_data=%0d want 1 %0d", i, wr_en, wr_data, 6 + i);
            else pass_cnt++;
            step();
            total_cnt++;
            if (bus.fifo_words !== 4'd2 || bus.data_out !== DW'(4 + i))
                $display("FAIL b2b_rd_%0d got words=%0d data_out=%0d want 2 %0d", i, bus.fifo_words, bus.data_out, 4 + i);
            else pass_cnt++;
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_clamp();
        hi_wm = CW'(10);
        for (int i = 0; i < 6; i++) step();
        total_cnt++;
        if (bus.fifo_words !== 4'd8 || bus.full !== 1'b1 || wr_en !== 1'b0 || refilling !== 1'b0)
            $display("FAIL clamp got words=%0d full=%b wr_en=%b refilling=%b want 8 1 0 0", bus.fifo_words, bus.full, wr_en, refilling);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.fifo_words !== 4'd8 || wr_data !== 8'd16)
            $display("FAIL clamp_hold got words=%0d wr_data=%0d want 8 16", bus.fifo_words, wr_data);
        else pass_cnt++;
    endtask

    task automatic test_empty_read();
        refill_en = 1'b0;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            total_cnt++;
            if (bus.data_out !== DW'(8 + i) || bus.fifo_words !== CW'(7 - i) || wr_en !== 1'b0)
                $display("FAIL empty_drain_%0d got data_out=%0d words=%0d wr_en=%b want %0d %0d 0", i, bus.data_out, bus.fifo_words, wr_en, 8 + i, 7 - i);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if (bus.fifo_words !== 4'd0 || bus.empty !== 1'b1 || bus.data_out !== 8'd15)
            $display("FAIL empty_read got words=%0d empty=%b data_out=%0d want 0 1 15", bus.fifo_words, bus.empty, bus.data_out);
        else pass_cnt++;
        bus.rd_en = 1'b0;
`ifdef WM_FIFO_ERR_EN
        total_cnt++; if (underflow !== 1'b1 || starved !== 1'b0) $display("FAIL underflow_set got %b %b want 1 0", underflow, starved); else pass_cnt++;
        step();
        total_cnt++; if (underflow !== 1'b1) $display("FAIL underflow_sticky got %b want 1", underflow); else pass_cnt++;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        total_cnt++; if (underflow !== 1'b0) $display("FAIL underflow_clear got %b want 0", underflow); else pass_cnt++;
`else
        total_cnt++; if (underflow !== 1'b0 || starved !== 1'b0) $display("FAIL flags_off got %b %b want 0 0", underflow, starved); else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid();
        hi_wm     = CW'(6);
        refill_en = 1'b1;
        step();
        step();
        step();
        total_cnt++;
        if (bus.fifo_words !== 4'd2 || refilling !== 1'b1 || wr_data !== 8'd18)
            $display("FAIL pre_rst got words=%0d refilling=%b wr_data=%0d want 2 1 18", bus.fifo_words, refilling, wr_data);
        else pass_cnt++;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total_cnt++;
        if (bus.fifo_words !== 4'd0 || bus.empty !== 1'b1 || refilling !== 1'b0 || wr_en !== 1'b0 || wr_data !== 8'd0 || bus.data_out !== 8'd0)
            $display("FAIL mid_rst got words=%0d empty=%b refilling=%b wr_en=%b wr_data=%0d data_out=%0d want 0 1 0 0 0 0",
                     bus.fifo_words, bus.empty, refilling, wr_en, wr_data, bus.data_out);
        else pass_cnt++;
        step();
        total_cnt++;
        if (wr_en !== 1'b1 || wr_data !== 8'd0)
            $display("FAIL post_rst_wr got wr_en=%b wr_data=%0d want 1 0", wr_en, wr_data);
        else pass_cnt++;
        step();
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        total_cnt++;
        if (bus.data_out !== 8'd0 || bus.fifo_words !== 4'd1)
            $display("FAIL post_rst_rd got data_out=%0d words=%0d want 0 1", bus.data_out, bus.fifo_words);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_clamp();
        test_empty_read();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
